mem_port_sequencer: RTL

MEM_PORT_SEQUENCER -- requirements
Module: mem_port_sequencer

---
 rtl/mem_seq_pkg.sv | 13 +
 rtl/rr_picker.sv | 31 +++
 rtl/mem_port_sequencer.sv | 86 ++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared mode constants and width helper for the memory port sequencer.
package mem_seq_pkg;
    localparam int MODE_TDM = 0;
    localparam int MODE_RR  = 1;

    // Never returns less than 1, so a select port always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: circular priority select of the first request at or after i_ptr.
module rr_picker #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx,
    output logic         o_vld
);
    logic [N-1:0] w_rot;
    int           w_j;

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        w_rot = '0;
        w_j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j   = (int'(i_ptr) + k) % N;
            w_rot = i_req >> w_j;
            if (w_rot[0]) begin
                o_idx = W'(w_j);
                o_vld = 1'b1;
            end
        end
        o_gnt = o_vld ? (N'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer: shares one single-ported memory among NUM_CH requesters
// using fixed TDM slots (MODE 0) or work-conserving round-robin (MODE 1).
module mem_port_sequencer
    import mem_seq_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MODE   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH-1:0]          ch_we,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]          ch_gnt,
    output logic [NUM_CH-1:0]          ch_rvalid,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic [clog2(NUM_CH)-1:0]   sel,
    output logic                       frame_start
);
    localparam int SEL_W = clog2(NUM_CH);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0]  r_slot, r_ptr, r_sel, w_rr_idx, w_idx;
    logic [NUM_CH-1:0] w_rr_gnt, w_gnt, r_rvalid;
    logic              w_rr_vld, w_any, r_en, r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    rr_picker #(.N(NUM_CH), .W(SEL_W)) u_pick (
        .i_req (ch_req),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_vld (w_rr_vld)
    );

    always_comb begin
        w_gnt = '0;
        if (rst_n) w_gnt = (MODE == MODE_RR) ? w_rr_gnt : (ch_req & (NUM_CH'(1) << r_slot));
        w_idx = (MODE == MODE_RR) ? w_rr_idx : r_slot;
        w_any = |w_gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot   <= '0;
            r_ptr    <= '0;
            r_sel    <= '0;
            r_en     <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rvalid <= '0;
        end else begin
            if (MODE == MODE_TDM) r_slot <= (r_slot == LAST) ? '0 : r_slot + 1'b1;
            if (MODE == MODE_RR && w_rr_vld) r_ptr <= (w_rr_idx == LAST) ? '0 : w_rr_idx + 1'b1;
            r_en <= w_any;
            r_we <= w_any & |(ch_we & w_gnt);
            if (w_any) begin
                r_addr  <= ADDR_W'(ch_addr >> (w_idx * ADDR_W));
                r_wdata <= DATA_W'(ch_wdata >> (w_idx * DATA_W));
                r_sel   <= w_idx;
            end
            // Read data returns the cycle after the strobe, so flag the owner then.
            r_rvalid <= (r_en && !r_we) ? (NUM_CH'(1) << r_sel) : '0;
        end
    end

    assign ch_gnt      = w_gnt;
    assign ch_rvalid   = r_rvalid;
    assign ch_rdata    = mem_rdata;
    assign mem_en      = r_en;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign sel         = r_sel;
    assign frame_start = (MODE == MODE_TDM) && (r_slot == '0);
endmodule
